drive_mode_arbiter: RTL and testbench

- Owns the car's architectural registers: power, run state (NSTART/START/MOVING) and moving_state.
- Shares them between three mode controllers (manual, semi-auto, auto). Each controller computes next_state/next_moving_state combinationally from the current registered values.
- Sequences power-up with a 1 s long-press and power-down on button, kill request or idle timeout.
- Gates mode changes so a switch never happens while the car is MOVING.

---
 rtl/drive_mode_arbiter.sv | 160 ++++++++++++++++
 tb/tb_drive_mode_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/drive_mode_arbiter.sv
// Arbitrates the car's power/run-state/moving-state registers between the manual,
// semi-auto and auto controllers, with long-press power-up and idle power-down.
module drive_mode_arbiter #(
    parameter int TICK_DIV = 100000,
    parameter int PON_MS   = 1000,
    parameter int IDLE_MS  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       power_off,
    input  logic [1:0] mode_sw,
    input  logic [1:0] m_next_state,
    input  logic [3:0] m_next_moving,
    input  logic       m_kill,
    input  logic [1:0] s_next_state,
    input  logic [3:0] s_next_moving,
    input  logic       s_kill,
    input  logic [1:0] a_next_state,
    input  logic [3:0] a_next_moving,
    input  logic       a_kill,
    output logic       power,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic [1:0] mode,
    output logic       mode_pending,
    output logic       arming
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (PON_MS   > 2) ? $clog2(PON_MS)   : 1;
    localparam int IW = (IDLE_MS  > 2) ? $clog2(IDLE_MS)  : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PON_LAST  = PW'(PON_MS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_MS - 1);

    localparam logic [1:0] NSTART = 2'b00;
    localparam logic [1:0] MOVING = 2'b10;

    typedef enum logic [1:0] {P_OFF, P_ARM, P_ON} pwr_e;

    pwr_e          pst_q, pst_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [PW-1:0] press_q, press_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    mov_q, mov_d;
    logic [1:0]    mode_q, mode_d;
    logic          pend_q, pend_d;

    logic       tick, pwr_on_q, act_kill, idle_to, off_req, legal, can_sw;
    logic [1:0] sel_ns, ns;
    logic [3:0] sel_nm, nm;

    assign tick     = (tick_q == TICK_LAST);
    assign pwr_on_q = (pst_q == P_ON);

    always_comb begin
        sel_ns   = m_next_state;
        sel_nm   = m_next_moving;
        act_kill = 1'b0;
        case (mode_q)
            2'd0: begin sel_ns = m_next_state; sel_nm = m_next_moving; act_kill = m_kill; end
            2'd1: begin sel_ns = s_next_state; sel_nm = s_next_moving; act_kill = s_kill; end
            2'd2: begin sel_ns = a_next_state; sel_nm = a_next_moving; act_kill = a_kill; end
            default: ;
        endcase
    end

    assign idle_to = pwr_on_q && (state_q == NSTART) && tick && (idle_q == IDLE_LAST);
    assign off_req = pwr_on_q && (power_off || act_kill || idle_to);

    // Power FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pst_q <= P_OFF;
        else      pst_q <= pst_d;
    end

    // Power FSM: next state
    always_comb begin
        pst_d   = pst_q;
        press_d = press_q;
        case (pst_q)
            P_OFF: if (power_on) begin
                pst_d   = P_ARM;
                press_d = '0;
            end
            P_ARM: begin
                if (!power_on) begin
                    pst_d   = P_OFF;
                    press_d = '0;
                end else if (tick) begin
                    if (press_q == PON_LAST) begin
                        pst_d   = P_ON;
                        press_d = '0;
                    end else begin
                        press_d = press_q + PW'(1);
                    end
                end
            end
            P_ON: if (off_req) pst_d = P_OFF;
            default: pst_d = P_OFF;
        endcase
    end

    // Power FSM: outputs (decoded from the state register, so still registered)
    always_comb begin
        power  = (pst_q == P_ON);
        arming = (pst_q == P_ARM);
    end

    // A power-off wins over a mode switch; the switch then lands a cycle later with power=0.
    assign legal  = (mode_sw != 2'b11) && (mode_sw != mode_q);
    assign can_sw = legal && !off_req && (!pwr_on_q || state_q != MOVING);

    always_comb begin
        ns = (sel_ns == 2'b11) ? state_q : sel_ns;
        nm = ((sel_nm & (sel_nm - 4'd1)) == 4'd0) ? sel_nm : 4'd0;
        if (ns != MOVING) nm = 4'd0;
    end

    always_comb begin
        tick_d  = tick ? '0 : tick_q + TW'(1);
        mode_d  = can_sw ? mode_sw : mode_q;
        pend_d  = legal && !can_sw;
        state_d = ns;
        mov_d   = nm;
        if (off_req || !pwr_on_q || can_sw) begin
            state_d = NSTART;
            mov_d   = 4'd0;
        end
        idle_d = idle_q;
        if (!pwr_on_q || state_q != NSTART) idle_d = '0;
        else if (tick)                      idle_d = (idle_q == IDLE_LAST) ? '0 : idle_q + IW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q  <= '0;
            press_q <= '0;
            idle_q  <= '0;
            state_q <= NSTART;
            mov_q   <= 4'd0;
            mode_q  <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            press_q <= press_d;
            idle_q  <= idle_d;
            state_q <= state_d;
            mov_q   <= mov_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
        end
    end

    assign state        = state_q;
    assign moving_state = mov_q;
    assign mode         = mode_q;
    assign mode_pending = pend_q;
endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Directed bench for drive_mode_arbiter: a per-cycle vector table for drive/kill/
// mode-switch/sanitisation plus hand sequences for power-up, idle-off and async reset.
module tb_drive_mode_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       power_on, power_off;
    logic [1:0] mode_sw;
    logic [1:0] m_next_state, s_next_state, a_next_state;
    logic [3:0] m_next_moving, s_next_moving, a_next_moving;
    logic       m_kill, s_kill, a_kill;
    logic       power, mode_pending, arming;
    logic [1:0] state, mode;
    logic [3:0] moving_state;

    int checks = 0;
    int errors = 0;

    drive_mode_arbiter #(.TICK_DIV(4), .PON_MS(5), .IDLE_MS(8)) dut (
        .clk(clk), .rst(rst), .power_on(power_on), .power_off(power_off), .mode_sw(mode_sw),
        .m_next_state(m_next_state), .m_next_moving(m_next_moving), .m_kill(m_kill),
        .s_next_state(s_next_state), .s_next_moving(s_next_moving), .s_kill(s_kill),
        .a_next_state(a_next_state), .a_next_moving(a_next_moving), .a_kill(a_kill),
        .power(power), .state(state), .moving_state(moving_state), .mode(mode),
        .mode_pending(mode_pending), .arming(arming)
    );

    always #5 clk = ~clk;

    // exp = {power, state, moving_state, mode, mode_pending}
    typedef struct {
        logic       off;
        logic [1:0] msw;
        logic [1:0] mns;
        logic [3:0] mnm;
        logic       mk;
        logic       sk;
        logic [1:0] ans;
        logic [3:0] anm;
        logic       ak;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic off, logic [1:0] msw, logic [1:0] mns, logic [3:0] mnm,
                                 logic mk, logic sk, logic [1:0] ans, logic [3:0] anm,
                                 logic ak, logic [9:0] exp);
        vec_t v;
        v.off = off; v.msw = msw; v.mns = mns; v.mnm = mnm; v.mk = mk; v.sk = sk;
        v.ans = ans; v.anm = anm; v.ak = ak; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        power_on = 0; power_off = 0; mode_sw = 2'd0;
        m_next_state = 0; m_next_moving = 0; m_kill = 0;
        s_next_state = 0; s_next_moving = 0; s_kill = 0;
        a_next_state = 0; a_next_moving = 0; a_kill = 0;
    endtask

    // Release lands on a negedge, so the next posedge is edge 1 with tick_cnt=0.
    task automatic do_reset();
        clr_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Ticks are consumed at edges 4,8,..; the 5th lands at edge 20.
    task automatic power_up();
        do_reset();
        power_on = 1'b1;
        repeat (20) step();
        power_on = 1'b0;
    endtask

    initial begin
        clr_inputs();
        rst = 1'b0;
        #12;
        chk("reset_outputs", {6'd0, power, state, moving_state, mode, mode_pending, arming}, 16'd0);

        // Full power-up press
        do_reset();
        power_on = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1)  chk("arm_start", {14'd0, arming, power}, 16'b10);
            if (i == 19) chk("arm_before_5th_tick", {14'd0, arming, power}, 16'b10);
            if (i == 20) chk("powered_after_5th_tick", {14'd0, arming, power}, 16'b01);
        end

        // Release at the 4th tick
        do_reset();
        power_on = 1'b1;
        repeat (16) step();
        power_on = 1'b0;
        step();
        chk("early_release_disarm", {14'd0, arming, power}, 16'b00);
        repeat (8) step();
        chk("early_release_stays_off", {15'd0, power}, 16'd0);

        // Per-cycle vector table starting from power=1, mode=manual, NSTART
        vecs.push_back(mkv(0, 0, 2, 4'b0100, 0, 0, 0, 0, 0, {1'b1, 2'd2, 4'b0100, 2'd0, 1'b0}));
        vecs.push_back(mkv(0, 0, 1, 4'b0001, 0, 0, 0, 0, 0, {1'b1, 2'd1, 4'b0000, 2'd0, 1'b0}));
        vecs.push_back(mkv(0, 0, 2, 4'b0100, 0, 1, 0, 0, 0, {1'b1, 2'd2, 4'b0100, 2'd0, 1'b0}));
        vecs.push_back(mkv(0, 0, 2, 4'b0100, 0, 0, 0, 0, 1, {1'b1, 2'd2, 4'b0100, 2'd0, 1'b0}));
        vecs.push_back(mkv(0, 0, 2, 4'b0011, 0, 0, 0, 0, 0, {1'b1, 2'd2, 4'b0000, 2'd0, 1'b0}));
        vecs.push_back(mkv(0, 0, 3, 4'b0001, 0, 0, 0, 0, 0, {1'b1, 2'd2, 4'b0001, 2'd0, 1'b0}));
        vecs.push_back(mkv(0, 0, 2, 4'b1000, 0, 0, 0, 0, 0, {1'b1, 2'd2, 4'b1000, 2'd0, 1'b0}));
        vecs.push_back(mkv(0, 2, 2, 4'b1000, 0, 0, 0, 0, 0, {1'b1, 2'd2, 4'b1000, 2'd0, 1'b1}));
        vecs.push_back(mkv(0, 3, 2, 4'b1000, 0, 0, 0, 0, 0, {1'b1, 2'd2, 4'b1000, 2'd0, 1'b0}));
        vecs.push_back(mkv(0, 2, 1, 4'b0001, 0, 0, 0, 0, 0, {1'b1, 2'd1, 4'b0000, 2'd0, 1'b1}));
        vecs.push_back(mkv(0, 2, 1, 4'b0001, 0, 0, 0, 0, 0, {1'b1, 2'd0, 4'b0000, 2'd2, 1'b0}));
        vecs.push_back(mkv(0, 2, 1, 4'b0000, 0, 0, 2, 4'b0001, 0, {1'b1, 2'd2, 4'b0001, 2'd2, 1'b0}));
        vecs.push_back(mkv(0, 2, 1, 4'b0000, 1, 0, 2, 4'b0001, 0, {1'b1, 2'd2, 4'b0001, 2'd2, 1'b0}));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 0, 2, 4'b0001, 0, {1'b1, 2'd2, 4'b0001, 2'd2, 1'b1}));
        vecs.push_back(mkv(0, 2, 0, 4'b0000, 0, 0, 2, 4'b0001, 0, {1'b1, 2'd2, 4'b0001, 2'd2, 1'b0}));
        vecs.push_back(mkv(0, 2, 0, 4'b0000, 0, 0, 2, 4'b0001, 1, {1'b0, 2'd0, 4'b0000, 2'd2, 1'b0}));
        vecs.push_back(mkv(0, 2, 0, 4'b0000, 0, 0, 2, 4'b0001, 0, {1'b0, 2'd0, 4'b0000, 2'd2, 1'b0}));
        vecs.push_back(mkv(0, 0, 0, 4'b0000, 0, 0, 2, 4'b0001, 0, {1'b0, 2'd0, 4'b0000, 2'd0, 1'b0}));
        vecs.push_back(mkv(1, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, {1'b0, 2'd0, 4'b0000, 2'd0, 1'b0}));

        power_up();
        chk("table_start_power", {15'd0, power}, 16'd1);
        for (int i = 0; i < vecs.size(); i++) begin
            power_off     = vecs[i].off;
            mode_sw       = vecs[i].msw;
            m_next_state  = vecs[i].mns;
            m_next_moving = vecs[i].mnm;
            m_kill        = vecs[i].mk;
            s_kill        = vecs[i].sk;
            a_next_state  = vecs[i].ans;
            a_next_moving = vecs[i].anm;
            a_kill        = vecs[i].ak;
            step();
            chk($sformatf("vec%0d", i),
                {6'd0, power, state, moving_state, mode, mode_pending}, {6'd0, vecs[i].exp});
        end
        clr_inputs();

        // Idle off: 8 ticks in NSTART after power-up (edges 24..52)
        power_up();
        repeat (31) step();
        chk("idle_before_8th_tick", {15'd0, power}, 16'd1);
        step();
        chk("idle_off_8th_tick", {15'd0, power}, 16'd0);

        // Idle restart: START pulse across tick 5 (edge 40) restarts the count
        power_up();
        repeat (18) step();
        m_next_state = 2'd1;
        step();
        chk("idle_pulse_start", {14'd0, state}, 16'd1);
        m_next_state = 2'd0;
        step();
        repeat (12) step();
        chk("idle_restart_survives_52", {15'd0, power}, 16'd1);
        repeat (19) step();
        chk("idle_restart_before_72", {15'd0, power}, 16'd1);
        step();
        chk("idle_restart_off_72", {15'd0, power}, 16'd0);

        // power_on + power_off together: arming starts, power_off ignored until ON
        do_reset();
        power_on = 1'b1;
        power_off = 1'b1;
        step();
        chk("on_off_arming", {15'd0, arming}, 16'd1);
        repeat (19) step();
        chk("on_off_powered", {15'd0, power}, 16'd1);
        step();
        chk("power_off_in_on", {15'd0, power}, 16'd0);
        clr_inputs();

        // Async reset mid-MOVING in semi mode with a pending switch
        power_up();
        mode_sw = 2'd1;
        step();
        chk("semi_mode", {14'd0, mode}, 16'd1);
        s_next_state = 2'd2;
        s_next_moving = 4'b0010;
        step();
        chk("semi_moving", {10'd0, state, moving_state}, {10'd0, 2'd2, 4'b0010});
        mode_sw = 2'd2;
        step();
        chk("semi_pending", {15'd0, mode_pending}, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", {6'd0, power, state, moving_state, mode, mode_pending, arming}, 16'd0);
        clr_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
